// File: rtl/bcd_scan_display_if.sv
// Pin-side bundle of the BCD scan display: digit data in, multiplexed
// segment/anode drive and status out.
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     dp_in;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame;
    logic                  err;

    modport master (
        output en, bcd, dp_in,
        input  seg, dp, an, frame, err
    );

    modport slave (
        input  en, bcd, dp_in,
        output seg, dp, an, frame, err
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Snapshots packed BCD digits once per frame and time-multiplexes their
// 7-segment patterns onto a shared bus with one-hot anodes.
module bcd_scan_display #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int ACTIVE_LOW = 0,
    parameter int BLANK_LZ   = 1
) (
    input  logic              c,
    input  logic              rst,
    bcd_scan_display_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
    localparam logic          INV  = (ACTIVE_LOW != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [DIGITS-1:0]   snapdp_q, snapdp_d;
    logic                err_q, err_d;
    logic                load;

    logic [DIGITS-1:0]   an_n, an_q;
    logic [6:0]          seg_n, seg_q;
    logic                dp_n, dp_q;
    logic                frame_q;
    logic [DIGITS-1:0]   zero_above;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pcnt_d   = pcnt_q;
        snap_d   = snap_q;
        snapdp_d = snapdp_q;
        err_d    = err_q;
        load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_LOAD;
                    load    = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = bus.en ? S_SHOW : S_IDLE;
                idx_d   = '0;
                pcnt_d  = '0;
            end
            S_SHOW: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    pcnt_d  = '0;
                end else if (pcnt_q == PMAX) begin
                    pcnt_d = '0;
                    if (idx_q == IMAX) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                        load    = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                pcnt_d  = '0;
            end
        endcase

        // The snapshot is taken on the edge that enters LOAD.
        if (load) begin
            snap_d   = bus.bcd;
            snapdp_d = bus.dp_in;
            for (int k = 0; k < DIGITS; k++) begin
                if (bus.bcd[4*k +: 4] > 4'd9) err_d = 1'b1;
            end
        end
    end

    // zero_above[k]: digit k and every more significant digit are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero      = all_zero && (snap_d[4*k +: 4] == 4'd0);
            zero_above[k] = all_zero;
        end
    end

    always_comb begin
        an_n  = '0;
        seg_n = '0;
        dp_n  = 1'b0;
        if (state_d == S_SHOW) begin
            an_n = DIGITS'(1) << idx_d;
            dp_n = snapdp_d[idx_d];
            if ((BLANK_LZ != 0) && (idx_d != '0) && zero_above[idx_d])
                seg_n = 7'h00;
            else
                seg_n = decode(snap_d[4*idx_d +: 4]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge c) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            pcnt_q   <= '0;
            snap_q   <= '0;
            snapdp_q <= '0;
            err_q    <= 1'b0;
            an_q     <= {DIGITS{INV}};
            seg_q    <= {7{INV}};
            dp_q     <= INV;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pcnt_q   <= pcnt_d;
            snap_q   <= snap_d;
            snapdp_q <= snapdp_d;
            err_q    <= err_d;
            an_q     <= an_n ^ {DIGITS{INV}};
            seg_q    <= seg_n ^ {7{INV}};
            dp_q     <= dp_n ^ INV;
            frame_q  <= (state_d == S_LOAD);
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.frame = frame_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench: reset, scan order, snapshot isolation, blanking, sticky
// error, enable/reset interruption, plus a PRESCALE=1 inverted-pin instance.
module tb_bcd_scan_display;
    logic c = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 c = ~c;

    bcd_scan_display_if #(.DIGITS(4)) bus ();
    bcd_scan_display_if #(.DIGITS(4)) bus2 ();

    bcd_scan_display #(
        .DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(0), .BLANK_LZ(1)
    ) dut (
        .c(c), .rst(rst), .bus(bus)
    );

    bcd_scan_display #(
        .DIGITS(4), .PRESCALE(1), .ACTIVE_LOW(1), .BLANK_LZ(1)
    ) dut_fast (
        .c(c), .rst(rst), .bus(bus2)
    );

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.en = 1'b1; bus.bcd = 16'h1234; bus.dp_in = 4'b0000;
        bus2.en = 1'b0; bus2.bcd = 16'h0907; bus2.dp_in = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus.an !== 4'b0000 || bus.seg !== 7'h00 || bus.dp !== 1'b0 ||
                bus.frame !== 1'b0 || bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset%0d: an=%b seg=%h dp=%b frame=%b err=%b, expected all zero",
                         i, bus.an, bus.seg, bus.dp, bus.frame, bus.err);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] segs [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [3:0] exp_an;
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.frame !== 1'b1 || bus.an !== 4'b0000) begin
            n_fail++;
            $display("FAIL first_load: frame=%b an=%b, expected frame=1 an=0000", bus.frame, bus.an);
        end
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                step();
                exp_an = 4'(1 << d);
                n_checks++;
                if (bus.an !== exp_an || bus.seg !== segs[d] || bus.frame !== 1'b0) begin
                    n_fail++;
                    $display("FAIL scan d%0d c%0d: an=%b seg=%h frame=%b, expected an=%b seg=%h frame=0",
                             d, p, bus.an, bus.seg, bus.frame, exp_an, segs[d]);
                end
            end
        end
        step();
        n_checks++;
        if (bus.frame !== 1'b1 || bus.an !== 4'b0000) begin
            n_fail++;
            $display("FAIL frame_period: frame=%b an=%b 17 cycles later, expected frame=1 an=0000",
                     bus.frame, bus.an);
        end
    endtask

    // bcd changes during digit 1; the rest of the frame must still show 1234.
    task automatic test_midframe();
        logic [6:0] segs [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [3:0] exp_an;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                step();
                if (d == 1 && p == 0) bus.bcd = 16'h5678;
                exp_an = 4'(1 << d);
                n_checks++;
                if (bus.an !== exp_an || bus.seg !== segs[d]) begin
                    n_fail++;
                    $display("FAIL stale d%0d c%0d: an=%b seg=%h, expected an=%b seg=%h",
                             d, p, bus.an, bus.seg, exp_an, segs[d]);
                end
            end
        end
        step();
        n_checks++;
        if (bus.frame !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_load: frame=%b, expected 1", bus.frame);
        end
    endtask

    task automatic test_lz();
        logic [6:0] segs_a [4] = '{7'h7F, 7'h07, 7'h7D, 7'h6D};
        logic [6:0] segs_b [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
        logic [3:0] dps_b = 4'b0100;
        logic [3:0] exp_an;
        bus.bcd = 16'h0050;
        bus.dp_in = 4'b0100;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                step();
                exp_an = 4'(1 << d);
                n_checks++;
                if (bus.an !== exp_an || bus.seg !== segs_a[d] || bus.dp !== 1'b0) begin
                    n_fail++;
                    $display("FAIL new_data d%0d c%0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=0",
                             d, p, bus.an, bus.seg, bus.dp, exp_an, segs_a[d]);
                end
            end
        end
        step();
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                step();
                exp_an = 4'(1 << d);
                n_checks++;
                if (bus.an !== exp_an || bus.seg !== segs_b[d] || bus.dp !== dps_b[d] ||
                    bus.err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL blank d%0d c%0d: an=%b seg=%h dp=%b err=%b, expected an=%b seg=%h dp=%b err=0",
                             d, p, bus.an, bus.seg, bus.dp, bus.err, exp_an, segs_b[d], dps_b[d]);
                end
            end
        end
        step();
    endtask

    task automatic test_err();
        logic [6:0] segs_a [4] = '{7'h3F, 7'h40, 7'h00, 7'h00};
        logic [6:0] segs_b [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
        logic [3:0] exp_an;
        bus.bcd = 16'h00A0;
        bus.dp_in = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL err_early c%0d: err=%b, expected 0", i, bus.err);
            end
        end
        step();
        bus.bcd = 16'h0000;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                step();
                exp_an = 4'(1 << d);
                n_checks++;
                if (bus.an !== exp_an || bus.seg !== segs_a[d] || bus.err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL invalid d%0d c%0d: an=%b seg=%h err=%b, expected an=%b seg=%h err=1",
                             d, p, bus.an, bus.seg, bus.err, exp_an, segs_a[d]);
                end
            end
        end
        step();
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                step();
                exp_an = 4'(1 << d);
                n_checks++;
                if (bus.an !== exp_an || bus.seg !== segs_b[d] || bus.err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err_sticky d%0d c%0d: an=%b seg=%h err=%b, expected an=%b seg=%h err=1",
                             d, p, bus.an, bus.seg, bus.err, exp_an, segs_b[d]);
                end
            end
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.err !== 1'b0 || bus.an !== 4'b0000 || bus.seg !== 7'h00 || bus.frame !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset: err=%b an=%b seg=%h frame=%b, expected all zero",
                     bus.err, bus.an, bus.seg, bus.frame);
        end
        rst = 1'b1;
    endtask

    task automatic test_disable();
        bus.bcd = 16'h1234;
        step();
        n_checks++;
        if (bus.frame !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_load: frame=%b, expected 1", bus.frame);
        end
        repeat (9) step();
        n_checks++;
        if (bus.an !== 4'b0100 || bus.seg !== 7'h5B) begin
            n_fail++;
            $display("FAIL dis_digit2: an=%b seg=%h, expected an=0100 seg=5B", bus.an, bus.seg);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus.an !== 4'b0000 || bus.seg !== 7'h00 || bus.frame !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled%0d: an=%b seg=%h frame=%b, expected an=0000 seg=00 frame=0",
                         i, bus.an, bus.seg, bus.frame);
            end
        end
        bus.en = 1'b1;
        step();
        n_checks++;
        if (bus.frame !== 1'b1 || bus.an !== 4'b0000) begin
            n_fail++;
            $display("FAIL reenable_load: frame=%b an=%b, expected frame=1 an=0000", bus.frame, bus.an);
        end
        step();
        n_checks++;
        if (bus.an !== 4'b0001 || bus.seg !== 7'h66) begin
            n_fail++;
            $display("FAIL reenable_digit0: an=%b seg=%h, expected an=0001 seg=66", bus.an, bus.seg);
        end
        repeat (5) step();
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.an !== 4'b0000 || bus.seg !== 7'h00 || bus.dp !== 1'b0 ||
            bus.frame !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_show_reset: an=%b seg=%h dp=%b frame=%b err=%b, expected all zero",
                     bus.an, bus.seg, bus.dp, bus.frame, bus.err);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.frame !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_load: frame=%b, expected 1", bus.frame);
        end
    endtask

    // PRESCALE=1, inverted pins: one digit per cycle, 5-cycle frame.
    task automatic test_fast_inverted();
        logic [3:0] an_pin  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_pin [4] = '{7'h78, 7'h40, 7'h10, 7'h7F};
        logic [3:0] dp_pin = 4'b1110;
        rst = 1'b0;
        step();
        n_checks++;
        if (bus2.an !== 4'b1111 || bus2.seg !== 7'h7F || bus2.dp !== 1'b1 ||
            bus2.frame !== 1'b0 || bus2.err !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_reset: an=%b seg=%h dp=%b frame=%b err=%b, expected an=1111 seg=7f dp=1 frame=0 err=0",
                     bus2.an, bus2.seg, bus2.dp, bus2.frame, bus2.err);
        end
        rst = 1'b1;
        bus2.en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            step();
            n_checks++;
            if (bus2.frame !== 1'b1 || bus2.an !== 4'b1111 || bus2.seg !== 7'h7F) begin
                n_fail++;
                $display("FAIL inv_load%0d: frame=%b an=%b seg=%h, expected frame=1 an=1111 seg=7f",
                         f, bus2.frame, bus2.an, bus2.seg);
            end
            for (int d = 0; d < 4; d++) begin
                step();
                n_checks++;
                if (bus2.an !== an_pin[d] || bus2.seg !== seg_pin[d] ||
                    bus2.dp !== dp_pin[d] || bus2.frame !== 1'b0) begin
                    n_fail++;
                    $display("FAIL inv_scan f%0d d%0d: an=%b seg=%h dp=%b frame=%b, expected an=%b seg=%h dp=%b frame=0",
                             f, d, bus2.an, bus2.seg, bus2.dp, bus2.frame, an_pin[d], seg_pin[d], dp_pin[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_lz();
        test_err();
        test_disable();
        test_fast_inverted();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
